// File: rtl/sm_div_unit.sv
// sm_div_unit: sign-magnitude fractional restoring divider, byte-serial I/O.
// Accepts a dividend (high byte, then low byte) and a divisor on ibus.
// Returns the quotient byte and then the remainder byte on obus.
// Optional macro SM_DIV_ROUND_EN: runs one extra guard iteration and rounds the quotient.
module sm_div_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         bgn,
  input  logic [W-1:0] ibus,
  output logic         fin,
  output logic         ovf,
  output logic [W-1:0] obus
);

`ifdef SM_DIV_ROUND_EN
  localparam int ITER = W;      // extra iteration yields a rounding guard bit
`else
  localparam int ITER = W - 1;  // truncating quotient
`endif
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_AH, S_LD_AL, S_LD_M, S_CHK, S_DIV, S_OUT_Q, S_OUT_R
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sgnq_q, sgnq_d;
  logic          sgnr_q, sgnr_d;
  logic          ovfr_q, ovfr_d;

  // Partial remainder with the next dividend bit shifted in, and its trial subtraction.
  logic [W-1:0]  p;
  logic [W-2:0]  diff;
  logic          ge;
  logic [W-2:0]  q_mag;
  logic [W-2:0]  r_mag;

  // Trial subtraction for one restoring step; diff only fits W-1 bits when ge holds.
  always_comb begin
    p    = {a_q[W-2:0], q_q[W-1]};
    ge   = (p >= {1'b0, m_q[W-2:0]});
    diff = p[W-2:0] - m_q[W-2:0];
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      ovfr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      ovfr_q  <= ovfr_d;
    end
  end

  // Next-state and datapath update for the load / check / divide / output sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    ovfr_d  = ovfr_q;
    case (state_q)
      S_IDLE: if (bgn) state_d = S_LD_AH;
      S_LD_AH: begin
        a_d     = ibus;
        state_d = S_LD_AL;
      end
      S_LD_AL: begin
        q_d     = {ibus[W-1:1], 1'b0};  // low dividend bit is not part of the magnitude
        state_d = S_LD_M;
      end
      S_LD_M: begin
        m_d     = ibus;
        cnt_d   = '0;
        state_d = S_CHK;
      end
      S_CHK: begin
        sgnq_d  = a_q[W-1] ^ m_q[W-1];
        sgnr_d  = a_q[W-1];
        // Quotient would not fit a fraction, or divisor is zero.
        ovfr_d  = (m_q[W-2:0] == '0) | (a_q[W-2:0] >= m_q[W-2:0]);
        state_d = ((m_q[W-2:0] == '0) | (a_q[W-2:0] >= m_q[W-2:0])) ? S_OUT_Q : S_DIV;
      end
      S_DIV: begin
        if (ge) begin
          a_d[W-2:0] = diff;
          q_d        = {q_q[W-2:0], 1'b1};
        end else begin
          a_d[W-2:0] = p[W-2:0];
          q_d        = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_OUT_Q;
      end
      S_OUT_Q: state_d = S_OUT_R;
      S_OUT_R: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SM_DIV_ROUND_EN
  logic [W-1:0] q_sum;
  // Round the quotient with the guard bit, saturating at the largest magnitude.
  always_comb begin
    q_sum = {1'b0, q_q[W-1:1]} + W'(q_q[0]);
    q_mag = q_sum[W-1] ? '1 : q_sum[W-2:0];
  end
`else
  // Truncated quotient is the low W-1 bits shifted in.
  always_comb begin
    q_mag = q_q[W-2:0];
  end
`endif

  // Moore output decode; zero magnitudes never carry a negative sign.
  always_comb begin
    r_mag = a_q[W-2:0];
    obus  = '0;
    fin   = 1'b0;
    ovf   = 1'b0;
    case (state_q)
      S_OUT_Q: begin
        ovf = ovfr_q;
        if (!ovfr_q) obus = {sgnq_q & (|q_mag), q_mag};
      end
      S_OUT_R: begin
        fin = 1'b1;
        ovf = ovfr_q;
        if (!ovfr_q) obus = {sgnr_q & (|r_mag), r_mag};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_div_unit.sv
// tb_sm_div_unit: directed-vector bench for sm_div_unit (handles SM_DIV_ROUND_EN builds too).
module tb_sm_div_unit;

  logic       clk;
  logic       rst_b;
  logic       bgn;
  logic [7:0] ibus;
  logic       fin;
  logic       ovf;
  logic [7:0] obus;

  int checks = 0;
  int errors = 0;

`ifdef SM_DIV_ROUND_EN
  localparam int QCYC = 13;
  localparam logic [7:0] C1_Q = 8'hCD, C1_R = 8'h83;
  localparam logic [7:0] C2_Q = 8'hBF, C2_R = 8'h0E;
  localparam logic [7:0] C5_Q = 8'h7F, C5_R = 8'h03;
  localparam logic [7:0] C6_Q = 8'h7F, C6_R = 8'h83;
`else
  localparam int QCYC = 12;
  localparam logic [7:0] C1_Q = 8'hCC, C1_R = 8'h84;
  localparam logic [7:0] C2_Q = 8'hBF, C2_R = 8'h07;
  localparam logic [7:0] C5_Q = 8'h7F, C5_R = 8'h04;
  localparam logic [7:0] C6_Q = 8'h7F, C6_R = 8'h84;
`endif

  sm_div_unit #(.W(8)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bgn  (bgn),
    .ibus (ibus),
    .fin  (fin),
    .ovf  (ovf),
    .obus (obus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle (#1 after the edge); ends in the IDLE cycle after OUT_R.
  task automatic run_op(input string name, input logic [7:0] ah, input logic [7:0] al,
                        input logic [7:0] m, input logic ov,
                        input logic [7:0] qe, input logic [7:0] re);
    int qc;
    logic [7:0] eo;
    logic [7:0] got_q;
    logic [7:0] got_r;
    got_q = '0;
    got_r = '0;
    qc = ov ? 5 : QCYC;
    bgn = 1'b1;
    step();
    bgn = 1'b0; ibus = ah; step();
    ibus = al; step();
    ibus = m;  step();
    ibus = 8'h00;
    for (int c = 4; c <= qc + 2; c++) begin
      eo = (c == qc) ? qe : ((c == qc + 1) ? re : 8'h00);
      if (c == qc) got_q = obus;
      if (c == qc + 1) got_r = obus;
      check($sformatf("%s c%0d obus", name, c), obus, eo);
      check($sformatf("%s c%0d fin", name, c), {7'b0, fin}, {7'b0, c == qc + 1});
      check($sformatf("%s c%0d ovf", name, c), {7'b0, ovf},
            {7'b0, ov && (c == qc || c == qc + 1)});
      if (c < qc + 2) step();
    end
    $display("op %s: in %h %h / %h -> q %h r %h (exp q %h r %h ovf %0d)",
             name, ah, al, m, got_q, got_r, qe, re, ov);
  endtask

  initial begin
    rst_b = 1'b0;
    bgn   = 1'b0;
    ibus  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset obus", obus, 8'h00);
    check("reset fin", {7'b0, fin}, 8'h00);
    check("reset ovf", {7'b0, ovf}, 8'h00);
    rst_b = 1'b1;
    step();

    run_op("basic",     8'h83, 8'h00, 8'h05, 1'b0, C1_Q, C1_R);
    run_op("mixed",     8'h0A, 8'h64, 8'h95, 1'b0, C2_Q, C2_R);
    run_op("ovf_eq",    8'h05, 8'h00, 8'h85, 1'b1, 8'h00, 8'h00);
    run_op("div_zero",  8'h05, 8'h00, 8'h80, 1'b1, 8'h00, 8'h00);
    run_op("zero_div",  8'h80, 8'h00, 8'h03, 1'b0, 8'h00, 8'h00);
    run_op("zero_lsb",  8'h80, 8'h01, 8'h03, 1'b0, 8'h00, 8'h00);
    run_op("max_q",     8'h04, 8'hFE, 8'h05, 1'b0, C5_Q, C5_R);
    run_op("neg_neg",   8'h84, 8'hFE, 8'h85, 1'b0, C6_Q, C6_R);

    // Reset during cycle 8 of an operation must abort it with no output.
    bgn = 1'b1; step();
    bgn = 1'b0; ibus = 8'h83; step();
    ibus = 8'h00; step();
    ibus = 8'h05; step();
    ibus = 8'h00;
    repeat (4) step();
    #3;
    rst_b = 1'b0;
    #1;
    check("midrst obus", obus, 8'h00);
    check("midrst fin", {7'b0, fin}, 8'h00);
    for (int c = 9; c <= 14; c++) begin
      step();
      check($sformatf("inrst c%0d obus", c), obus, 8'h00);
      check($sformatf("inrst c%0d fin", c), {7'b0, fin}, 8'h00);
    end
    rst_b = 1'b1;
    step();
    $display("op midreset: aborted in cycle 8, outputs held at zero");
    run_op("after_rst", 8'h83, 8'h00, 8'h05, 1'b0, C1_Q, C1_R);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
